// File: rtl/booth_seq_divider.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, then a sign-fix cycle.
// Optional overflow flag for -MIN / -1 when BOOTH_DIV_OVF_FLAG_EN is defined.
module booth_seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
`ifdef BOOTH_DIV_OVF_FLAG_EN
  output logic                    ovf,
`endif
  output logic                    div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_ZERO} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]        dvd_mag;
  logic [WIDTH-1:0]        dvs_mag;
  logic [WIDTH:0]          prem;
  logic [CNT_W-1:0]        count;
  logic                    sign_q;
  logic                    sign_r;
  logic signed [WIDTH-1:0] dvd_raw;
  logic [WIDTH+1:0]        trial;
  logic                    q_bit;
  logic                    last_iter;
  logic                    load_op;
  logic                    step;
`ifdef BOOTH_DIV_OVF_FLAG_EN
  logic                    ovf_hit;
`endif

  // |v| as unsigned; the most negative value maps onto its own bit pattern.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? (~u + WIDTH'(1)) : u;
  endfunction

  // Two's-complement negate on request, wrapping modulo 2**WIDTH.
  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] m);
    return neg ? (~m + WIDTH'(1)) : m;
  endfunction

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    trial     = {prem, dvd_mag[WIDTH-1]} - {2'b00, dvs_mag};
    q_bit     = ~trial[WIDTH+1];
    last_iter = (count == CNT_W'(WIDTH-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (divisor == '0) ? S_ZERO : S_RUN;
      S_RUN:   if (last_iter) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      S_ZERO:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    load_op = (state == S_IDLE) && start;
    step    = (state == S_RUN);
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_mag <= '0;
      dvs_mag <= '0;
      prem    <= '0;
      count   <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dvd_raw <= '0;
`ifdef BOOTH_DIV_OVF_FLAG_EN
      ovf_hit <= 1'b0;
`endif
    end else if (load_op) begin
      dvd_mag <= mag(dividend);
      dvs_mag <= mag(divisor);
      prem    <= '0;
      count   <= '0;
      sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r  <= dividend[WIDTH-1];
      dvd_raw <= dividend;
`ifdef BOOTH_DIV_OVF_FLAG_EN
      ovf_hit <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`endif
    end else if (step) begin
      prem    <= q_bit ? trial[WIDTH:0] : {prem[WIDTH-1:0], dvd_mag[WIDTH-1]};
      dvd_mag <= {dvd_mag[WIDTH-2:0], q_bit};
      count   <= count + 1'b1;
    end
  end

  // Result registers only move on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef BOOTH_DIV_OVF_FLAG_EN
      ovf         <= 1'b0;
`endif
    end else begin
      done <= (state == S_FIX) || (state == S_ZERO);
      if (state == S_FIX) begin
        quotient    <= apply_sign(sign_q, dvd_mag);
        remainder   <= apply_sign(sign_r, prem[WIDTH-1:0]);
        div_by_zero <= 1'b0;
`ifdef BOOTH_DIV_OVF_FLAG_EN
        ovf         <= ovf_hit;
`endif
      end else if (state == S_ZERO) begin
        quotient    <= '1;
        remainder   <= dvd_raw;
        div_by_zero <= 1'b1;
`ifdef BOOTH_DIV_OVF_FLAG_EN
        ovf         <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Bench for booth_seq_divider: fixed vector table, handshake/reset sequences and random ops.
module tb_booth_seq_divider;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic signed [7:0] dividend;
  logic signed [7:0] divisor;
  logic              busy;
  logic              done;
  logic signed [7:0] quotient;
  logic signed [7:0] remainder;
  logic              div_by_zero;
`ifdef BOOTH_DIV_OVF_FLAG_EN
  logic              ovf;
`endif

  int nvec = 0;
  int nerr = 0;

  booth_seq_divider #(.WIDTH(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
`ifdef BOOTH_DIV_OVF_FLAG_EN
    .ovf         (ovf),
`endif
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic [7:0]        q;
    logic [7:0]        r;
    logic              z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: C-style truncating division in plain integer arithmetic.
  task automatic model(input logic signed [7:0] a, input logic signed [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic z);
    int qi, ri;
    if (b == 0) begin
      q = 8'hFF; r = a; z = 1'b1;
    end else begin
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
      q = qi[7:0]; r = ri[7:0]; z = 1'b0;
    end
  endtask

  task automatic issue(input logic signed [7:0] a, input logic signed [7:0] b);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the negedge after the accepting edge; returns edges until done is seen.
  task automatic wait_done(input bit glitch, output int lat, output bit busy_ok);
    lat = 0; busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (glitch) begin
        start = (lat == 3 || lat == 5);
        if (start) begin dividend = 8'sd50; divisor = 8'sd5; end
      end
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (busy) busy_ok = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic signed [7:0] a, input logic signed [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic ez);
    chk({tag, " quotient"},    {24'b0, quotient},    {24'b0, eq});
    chk({tag, " remainder"},   {24'b0, remainder},   {24'b0, er});
    chk({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, ez});
`ifdef BOOTH_DIV_OVF_FLAG_EN
    chk({tag, " ovf"}, {31'b0, ovf}, {31'b0, (a == -8'sd128) && (b == -8'sd1)});
`else
    if (a == b && a != a) $display("unreachable");
`endif
  endtask

  task automatic run_op(input string tag, input logic signed [7:0] a, input logic signed [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ez, input bit glitch);
    int lat;
    bit bok;
    issue(a, b);
    wait_done(glitch, lat, bok);
    chk({tag, " latency"}, 32'(lat), ez ? 32'd1 : 32'd9);
    chk({tag, " busy"}, {31'b0, bok}, 32'd1);
    check_res(tag, a, b, eq, er, ez);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int lat, lat2, seen;
    bit bok;
    logic [7:0] mq, mr;
    logic mz;
    logic signed [7:0] ra, rb;

    tbl[0] = '{8'sd100,  8'sd7,   8'd14,  8'd2,   1'b0};
    tbl[1] = '{-8'sd100, 8'sd7,   8'hF2,  8'hFE,  1'b0};
    tbl[2] = '{8'sd100,  -8'sd7,  8'hF2,  8'h02,  1'b0};
    tbl[3] = '{-8'sd100, -8'sd7,  8'h0E,  8'hFE,  1'b0};
    tbl[4] = '{8'sd5,    8'sd9,   8'h00,  8'h05,  1'b0};
    tbl[5] = '{-8'sd128, 8'sd1,   8'h80,  8'h00,  1'b0};
    tbl[6] = '{8'sd37,   8'sd0,   8'hFF,  8'd37,  1'b1};
    tbl[7] = '{8'sd6,    8'sd3,   8'h02,  8'h00,  1'b0};
    tbl[8] = '{-8'sd128, -8'sd1,  8'h80,  8'h00,  1'b0};
    tbl[9] = '{8'sd6,    8'sd3,   8'h02,  8'h00,  1'b0};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset quotient", {24'b0, quotient}, 32'd0);
    chk("reset remainder", {24'b0, remainder}, 32'd0);
    chk("reset div_by_zero", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, 1'b0);

    // Start pulses while busy must not disturb the running op.
    run_op("glitch", 8'sd100, 8'sd7, 8'd14, 8'd2, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("glitch idle", {31'b0, busy}, 32'd0);

    // Start held through the done cycle: second op accepted one edge later.
    @(negedge clk);
    dividend = 8'sd100; divisor = 8'sd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = -8'sd90; divisor = 8'sd4;
    wait_done(1'b0, lat, bok);
    chk("held first latency", 32'(lat), 32'd9);
    check_res("held first", 8'sd100, 8'sd7, 8'd14, 8'd2, 1'b0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, lat2, bok);
    chk("held second spacing", 32'(lat2 + 1), 32'd10);
    check_res("held second", -8'sd90, 8'sd4, 8'hEA, 8'hFE, 1'b0);

    // Asynchronous reset mid-iteration clears outputs and drops the op.
    run_op("pre-reset zero", 8'sd37, 8'sd0, 8'hFF, 8'd37, 1'b1, 1'b0);
    issue(8'sd100, 8'sd7);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    #2 rst = 1'b1;
    #1;
    chk("async rst quotient", {24'b0, quotient}, 32'd0);
    chk("async rst remainder", {24'b0, remainder}, 32'd0);
    chk("async rst div_by_zero", {31'b0, div_by_zero}, 32'd0);
    chk("async rst busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (done) seen++; end
    chk("abandoned no done", 32'(seen), 32'd0);
    run_op("post-reset", 8'sd50, 8'sd5, 8'd10, 8'd0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'sd0 : 8'($urandom);
      model(ra, rb, mq, mr, mz);
      run_op($sformatf("rand%0d %0d/%0d", k, ra, rb), ra, rb, mq, mr, mz, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
